// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver for the SoC UART RX path.
// Frames start / 8 data (LSB first) / [parity] / stop. Each byte goes into
// a valid/ack holding register. Frame and overrun status are reported as
// single-cycle pulses.
// Build option: define UART_RX_PARITY_EN to add a parity bit before the stop
// bit. PARITY_ODD selects its sense. Without the macro, parity_err is tied to 0.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] clk_div,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err,
  output logic        busy
);

  // Tick counter width covers OVERSAMPLE up to 32.
  localparam int TW = 6;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  // Reject parameter values the tick arithmetic cannot represent.
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_core: OVERSAMPLE must be even in 8..32, PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;

  // Synchronizer and edge-detect history. These idle high, like the line.
  logic            rx_meta_q, rxs_q, rx_prev_q;

  // Oversample tick generation and position within the current bit.
  logic [15:0]     cnt_q, cnt_d;
  logic            tick;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  // Data assembly.
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            dlv_q, dlv_d;

  // Holding register and status pulses.
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic            par_mis_q, par_mis_d;
  logic            parity_err_q, parity_err_d;
`endif

  // Decoded strobes produced by the output process.
  logic            start_det;
  logic            samp;

  assign tick = (cnt_q == clk_div);

  // Synchronize the asynchronous line and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
      rx_prev_q <= rxs_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_det) state_d = S_START;
      end
      S_START: begin
        // A high line at mid start bit was a glitch, not a frame.
        if (samp) state_d = rxs_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (samp && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (samp) state_d = S_STOP;
      end
      S_STOP: begin
        if (samp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag, start-edge detect and the mid-bit sample strobe.
  always_comb begin
    busy      = (state_q != S_IDLE);
    // Only a real 1->0 transition starts a frame. A line held low (break)
    // cannot restart until it has been seen high again.
    start_det = (state_q == S_IDLE) && rx_prev_q && !rxs_q;
    samp      = 1'b0;
    case (state_q)
      S_START:                  samp = tick && (tcnt_q == HALF_M1);
      S_DATA, S_PARITY, S_STOP: samp = tick && (tcnt_q == FULL_M1);
      default:                  samp = 1'b0;
    endcase
  end

  // Datapath next-state: tick counters, shifter, delivery and status pulses.
  always_comb begin
    // Divider realigns to the start edge so the sample points are centred.
    if (start_det || tick) cnt_d = 16'd0;
    else                   cnt_d = cnt_q + 16'd1;

    tcnt_d = tcnt_q;
    if (state_q == S_IDLE)  tcnt_d = '0;
    else if (samp)          tcnt_d = '0;
    else if (tick)          tcnt_d = tcnt_q + 6'd1;

    bit_d   = bit_q;
    shift_d = shift_q;
    if (start_det) begin
      bit_d = 3'd0;
    end else if (state_q == S_DATA && samp) begin
      bit_d   = bit_q + 3'd1;
      shift_d = {rxs_q, shift_q[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    par_mis_d = par_mis_q;
    if (start_det)                        par_mis_d = 1'b0;
    else if (state_q == S_PARITY && samp) par_mis_d = rxs_q ^ (^shift_q) ^ PAR_SENSE;
`endif

    // A good stop bit schedules delivery for the next cycle. A bad one
    // discards the byte and reports a framing error instead.
    dlv_d       = (state_q == S_STOP) && samp && rxs_q;
    frame_err_d = (state_q == S_STOP) && samp && !rxs_q;

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (rx_ack) rx_valid_d = 1'b0;
    if (dlv_q) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_mis_q;
`endif
      end else begin
        // The consumer still holds the previous byte, so the new one is dropped.
        overrun_d = 1'b1;
      end
    end
  end

  // Datapath registers. Reset clears everything, including the held byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= 16'd0;
      tcnt_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      dlv_q        <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      dlv_q        <= dlv_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_mis_q    <= par_mis_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
